control_unit: RTL and testbench
===============================

# control_unit

Instruction-sequencing controller for the 16-bit programmable processor. It runs the fetch/decode/execute state machine and drives every datapath control line: program counter, instruction register load, data-memory address and write enable, and register-file addresses and write enable. It also drives the ALU function select and the RFSelect line of the register-file write-data 2:1 mux, which chooses ALU result (0) or memory ReadData (1). It sits between the instruction register and the datapath (register file, ALU, data memory).

## Interface
- No parameters. Opcode width is 4 bits, data address 8 bits, register address 4 bits.
- Clk  input  1  system clock, all state changes on rising edge
- ResetN  input  1  asynchronous, active-low reset; forces state Init immediately
- IR  input  16  current instruction register contents; IR[15:12]=opcode
- PC_clr  output  1  clear program counter
- PC_up  output  1  increment program counter
- IR_ld  output  1  load instruction register from instruction memory
- D_addr  output  8  data-memory address
- D_wr  output  1  data-memory write enable
- RFSelect  output  1  register-file write-data mux select: 0=ALUQ, 1=ReadData
- RF_W_addr  output  4  register-file write address
- RF_W_en  output  1  register-file write enable
- RF_Ra_addr  output  4  register-file read port A address
- RF_Rb_addr  output  4  register-file read port B address
- ALU_s0  output  3  ALU function: 000 pass/zero, 001 add, 010 subtract
- OutState  output  4  current state encoding, for debug/display

## Operation
- Opcodes: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT; 0110–1111 are treated as NOOP.
- States and encodings (OutState): Init=0, Fetch=1, Decode=2, NOOP=3, Load_A=4, Load_B=5, Store=6, Add=7, Sub=8, Halt=9.
- Transitions:
  - Init→Fetch.
  - Fetch→Decode.
  - Decode→state selected by opcode; undefined opcodes go to NOOP.
  - NOOP, Store, Add, Sub and Load_B each go to Fetch.
  - Load_A→Load_B.
  - Halt→Halt until ResetN is asserted.
- Outputs are Moore-style: a combinational function of the current state plus IR fields. Every output defaults to 0 unless listed below.
  - Init: PC_clr=1.
  - Fetch: IR_ld=1, PC_up=1.
  - Decode: D_addr=IR[7:0], RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4]. These are pre-set for the next state; nothing is written.
  - Load_A: D_addr=IR[7:0], RFSelect=1, RF_W_addr=IR[11:8], RF_W_en=0. This state covers memory read latency.
  - Load_B: same as Load_A, but RF_W_en=1.
  - Store: D_addr=IR[7:0], D_wr=1, RF_Ra_addr=IR[11:8].
  - Add: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], RF_W_en=1, RFSelect=0, ALU_s0=001.
  - Sub: same as Add, but ALU_s0=010.
  - NOOP, Halt: all outputs 0.
- RFSelect=1 only in Load_A and Load_B. RF_W_en and D_wr are never both 1.

## Timing
- State register updates on the rising edge of Clk. ResetN low forces state Init asynchronously, and the state holds at Init while ResetN is low.
- Reset values (Init): PC_clr=1, OutState=0; every other output is 0.
- Instruction latency, counted from entering Fetch:
  - NOOP/STORE/ADD/SUB/undefined: 3 cycles (Fetch, Decode, exec).
  - LOAD: 4 cycles (Fetch, Decode, Load_A, Load_B).
  - HALT: enters Halt at cycle 3 and stays there.
- IR is loaded at the end of Fetch, so IR is valid from Decode onward. IR must not change between Decode and the end of the execute state.
- Reset mid-instruction (e.g. during Load_A or Store): the state goes to Init at once, and D_wr and RF_W_en drop in the same instant, with no clock edge required. After ResetN deasserts, the first rising edge moves the state to Fetch.
- Any output not explicitly driven in the current state is 0. No latches; outputs must not glitch based on IR fields that the current state does not use.

## Test plan
- Reset: ResetN=0 while in Add → OutState=0, PC_clr=1, RF_W_en=0 with no clock edge; release ResetN → next edge OutState=1 with IR_ld=1 and PC_up=1.
- ADD: IR=16'h3123 → Fetch(1), Decode(2), Add(7) with RF_Ra_addr=1, RF_Rb_addr=2, RF_W_addr=3, RF_W_en=1, ALU_s0=001, RFSelect=0; then Fetch.
- SUB then STORE: IR=16'h4456 → Sub(8) with ALU_s0=010 and W_addr=6. Next IR=16'h1A3C → Store(6) with D_addr=8'h3C, D_wr=1, RF_Ra_addr=4'hA, RF_W_en=0.
- LOAD: IR=16'h2705 → Load_A(4) with D_addr=5, RFSelect=1, RF_W_en=0, then Load_B(5) with RF_W_addr=7, RF_W_en=1, RFSelect=1; then Fetch. Total 4 cycles.
- Undefined/NOOP/HALT: IR=16'hF000 → NOOP(3) with all outputs 0, then Fetch. IR=16'h5000 → Halt(9) holds for 20 cycles with all outputs 0; ResetN pulse → Init.

Source files
------------

// File: rtl/control_unit_if.sv
// Datapath control bundle between the instruction sequencer and the datapath.
// The master side reads IR and drives every control line.
interface control_unit_if;
  logic [15:0] IR;
  logic        PC_clr;
  logic        PC_up;
  logic        IR_ld;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RFSelect;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  ALU_s0;
  logic [3:0]  OutState;

  modport master (
    input  IR,
    output PC_clr, PC_up, IR_ld, D_addr, D_wr, RFSelect, RF_W_addr,
           RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0, OutState
  );

  modport slave (
    output IR,
    input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RFSelect, RF_W_addr,
           RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0, OutState
  );
endinterface

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 16-bit processor. Outputs are a Moore
// function of the state register, so an asynchronous reset drops them at once.
module control_unit (
  input logic            Clk,
  input logic            ResetN,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t      state_r;
  state_t      next_state_s;

  logic        pc_clr_s;
  logic        pc_up_s;
  logic        ir_ld_s;
  logic [7:0]  d_addr_s;
  logic        d_wr_s;
  logic        rf_select_s;
  logic [3:0]  rf_w_addr_s;
  logic        rf_w_en_s;
  logic [3:0]  rf_ra_addr_s;
  logic [3:0]  rf_rb_addr_s;
  logic [2:0]  alu_s0_s;

  // State register
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_r <= S_INIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; unused encodings recover through Init
  always_comb begin
    next_state_s = S_INIT;
    case (state_r)
      S_INIT:   next_state_s = S_FETCH;
      S_FETCH:  next_state_s = S_DECODE;
      S_DECODE: begin
        case (bus.IR[15:12])
          4'b0001: next_state_s = S_STORE;
          4'b0010: next_state_s = S_LOAD_A;
          4'b0011: next_state_s = S_ADD;
          4'b0100: next_state_s = S_SUB;
          4'b0101: next_state_s = S_HALT;
          default: next_state_s = S_NOOP;
        endcase
      end
      S_LOAD_A: next_state_s = S_LOAD_B;
      S_NOOP,
      S_LOAD_B,
      S_STORE,
      S_ADD,
      S_SUB:    next_state_s = S_FETCH;
      S_HALT:   next_state_s = S_HALT;
      default:  next_state_s = S_INIT;
    endcase
  end

  // Control outputs; IR fields pass through only in states that use them
  always_comb begin
    pc_clr_s     = 1'b0;
    pc_up_s      = 1'b0;
    ir_ld_s      = 1'b0;
    d_addr_s     = 8'h00;
    d_wr_s       = 1'b0;
    rf_select_s  = 1'b0;
    rf_w_addr_s  = 4'h0;
    rf_w_en_s    = 1'b0;
    rf_ra_addr_s = 4'h0;
    rf_rb_addr_s = 4'h0;
    alu_s0_s     = 3'b000;
    case (state_r)
      S_INIT:   pc_clr_s = 1'b1;
      S_FETCH: begin
        ir_ld_s = 1'b1;
        pc_up_s = 1'b1;
      end
      S_DECODE: begin
        d_addr_s     = bus.IR[7:0];
        rf_ra_addr_s = bus.IR[11:8];
        rf_rb_addr_s = bus.IR[7:4];
      end
      S_LOAD_A, S_LOAD_B: begin
        d_addr_s    = bus.IR[7:0];
        rf_select_s = 1'b1;
        rf_w_addr_s = bus.IR[11:8];
        rf_w_en_s   = (state_r == S_LOAD_B) ? 1'b1 : 1'b0;
      end
      S_STORE: begin
        d_addr_s     = bus.IR[7:0];
        d_wr_s       = 1'b1;
        rf_ra_addr_s = bus.IR[11:8];
      end
      S_ADD, S_SUB: begin
        rf_ra_addr_s = bus.IR[11:8];
        rf_rb_addr_s = bus.IR[7:4];
        rf_w_addr_s  = bus.IR[3:0];
        rf_w_en_s    = 1'b1;
        alu_s0_s     = (state_r == S_SUB) ? 3'b010 : 3'b001;
      end
      default: ;
    endcase
  end

  assign bus.PC_clr     = pc_clr_s;
  assign bus.PC_up      = pc_up_s;
  assign bus.IR_ld      = ir_ld_s;
  assign bus.D_addr     = d_addr_s;
  assign bus.D_wr       = d_wr_s;
  assign bus.RFSelect   = rf_select_s;
  assign bus.RF_W_addr  = rf_w_addr_s;
  assign bus.RF_W_en    = rf_w_en_s;
  assign bus.RF_Ra_addr = rf_ra_addr_s;
  assign bus.RF_Rb_addr = rf_rb_addr_s;
  assign bus.ALU_s0     = alu_s0_s;
  assign bus.OutState   = state_r;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class through its
// state sequence and checks every control output against hand-derived values.
module tb_control_unit;

  logic Clk;
  logic ResetN;
  int   n_tests;
  int   n_fail;

  control_unit_if bus ();

  control_unit dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus.master)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Packing order: PC_clr PC_up IR_ld D_addr D_wr RFSelect W_addr W_en Ra Rb ALU OutState
  function automatic logic [32:0] pack(
    input logic pc_clr, input logic pc_up, input logic ir_ld, input logic [7:0] d_addr,
    input logic d_wr, input logic rfsel, input logic [3:0] w_addr, input logic w_en,
    input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] alu, input logic [3:0] st);
    return {pc_clr, pc_up, ir_ld, d_addr, d_wr, rfsel, w_addr, w_en, ra, rb, alu, st};
  endfunction

  function automatic logic [32:0] obs();
    return {bus.PC_clr, bus.PC_up, bus.IR_ld, bus.D_addr, bus.D_wr, bus.RFSelect,
            bus.RF_W_addr, bus.RF_W_en, bus.RF_Ra_addr, bus.RF_Rb_addr, bus.ALU_s0,
            bus.OutState};
  endfunction

  logic [32:0] got;
  logic [32:0] exp;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    bus.IR = 16'h0000;
    #3;
    got = obs(); exp = pack(1,0,0,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd0); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_init: got %h expected %h", got, exp); end
    step(); step();
    got = obs(); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", got, exp); end
    @(negedge Clk);
    ResetN = 1'b1;
    step();
    got = obs(); exp = pack(0,1,1,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd1); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_release_fetch: got %h expected %h", got, exp); end
  endtask

  task automatic test_add();
    bus.IR = 16'h3123;
    step();
    got = obs(); exp = pack(0,0,0,8'h23,0,0,4'h0,0,4'h1,4'h2,3'd0,4'd2); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL add_decode: got %h expected %h", got, exp); end
    step();
    got = obs(); exp = pack(0,0,0,8'h00,0,0,4'h3,1,4'h1,4'h2,3'b001,4'd7); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL add_exec: got %h expected %h", got, exp); end
    step();
    got = obs(); exp = pack(0,1,1,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd1); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL add_back_to_fetch: got %h expected %h", got, exp); end
  endtask

  task automatic test_sub_store();
    bus.IR = 16'h4456;
    step();
    got = obs(); exp = pack(0,0,0,8'h56,0,0,4'h0,0,4'h4,4'h5,3'd0,4'd2); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL sub_decode: got %h expected %h", got, exp); end
    step();
    got = obs(); exp = pack(0,0,0,8'h00,0,0,4'h6,1,4'h4,4'h5,3'b010,4'd8); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL sub_exec: got %h expected %h", got, exp); end
    step();
    bus.IR = 16'h1A3C;
    step();
    got = obs(); exp = pack(0,0,0,8'h3C,0,0,4'h0,0,4'hA,4'h3,3'd0,4'd2); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL store_decode: got %h expected %h", got, exp); end
    step();
    got = obs(); exp = pack(0,0,0,8'h3C,1,0,4'h0,0,4'hA,4'h0,3'd0,4'd6); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL store_exec: got %h expected %h", got, exp); end
    step();
    got = obs(); exp = pack(0,1,1,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd1); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL store_back_to_fetch: got %h expected %h", got, exp); end
  endtask

  task automatic test_load();
    bus.IR = 16'h2705;
    step();
    step();
    got = obs(); exp = pack(0,0,0,8'h05,0,1,4'h7,0,4'h0,4'h0,3'd0,4'd4); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL load_a: got %h expected %h", got, exp); end
    step();
    got = obs(); exp = pack(0,0,0,8'h05,0,1,4'h7,1,4'h0,4'h0,3'd0,4'd5); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL load_b: got %h expected %h", got, exp); end
    step();
    got = obs(); exp = pack(0,1,1,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd1); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL load_back_to_fetch: got %h expected %h", got, exp); end
  endtask

  task automatic test_noop();
    bus.IR = 16'hF000;
    step();
    step();
    got = obs(); exp = pack(0,0,0,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd3); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL undefined_as_noop: got %h expected %h", got, exp); end
    step();
    bus.IR = 16'h0FFF;
    step();
    got = obs(); exp = pack(0,0,0,8'hFF,0,0,4'h0,0,4'hF,4'hF,3'd0,4'd2); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL noop_decode: got %h expected %h", got, exp); end
    step();
    got = obs(); exp = pack(0,0,0,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd3); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL noop_exec: got %h expected %h", got, exp); end
    step();
    got = obs(); exp = pack(0,1,1,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd1); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL noop_back_to_fetch: got %h expected %h", got, exp); end
  endtask

  task automatic test_reset_mid();
    bus.IR = 16'h3123;
    step();
    step();
    got = obs(); exp = pack(0,0,0,8'h00,0,0,4'h3,1,4'h1,4'h2,3'b001,4'd7); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL mid_add_before_reset: got %h expected %h", got, exp); end
    #2;
    ResetN = 1'b0;
    #1;
    got = obs(); exp = pack(1,0,0,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd0); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL mid_add_async_reset: got %h expected %h", got, exp); end
    @(negedge Clk);
    ResetN = 1'b1;
    step();
    bus.IR = 16'h1A3C;
    step();
    step();
    got = obs(); exp = pack(0,0,0,8'h3C,1,0,4'h0,0,4'hA,4'h0,3'd0,4'd6); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL mid_store_before_reset: got %h expected %h", got, exp); end
    #2;
    ResetN = 1'b0;
    #1;
    got = obs(); exp = pack(1,0,0,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd0); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL mid_store_async_reset: got %h expected %h", got, exp); end
    @(negedge Clk);
    ResetN = 1'b1;
    step();
    got = obs(); exp = pack(0,1,1,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd1); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL mid_reset_release_fetch: got %h expected %h", got, exp); end
  endtask

  task automatic test_halt();
    bus.IR = 16'h5000;
    step();
    exp = pack(0,0,0,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd9);
    for (int i = 0; i < 20; i++) begin
      step();
      got = obs(); n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL halt_hold cycle %0d: got %h expected %h", i, got, exp); end
    end
    @(negedge Clk);
    ResetN = 1'b0;
    #1;
    got = obs(); exp = pack(1,0,0,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd0); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL halt_reset: got %h expected %h", got, exp); end
    @(negedge Clk);
    ResetN = 1'b1;
    step();
    got = obs(); exp = pack(0,1,1,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd1); n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL halt_release_fetch: got %h expected %h", got, exp); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_add();
    test_sub_store();
    test_load();
    test_noop();
    test_reset_mid();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
